// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: stall/flush control, EX forwarding
// selects and a data-memory wait FSM. States: RUN | normal flow, WAIT | holding for dmem_ack.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_d,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rd_d,
    input  logic       regwrt_d,
    input  logic [1:0] rsltSrc_d,
    input  logic       memacc_d,
    input  logic       pc_src_e,
    input  logic       dmem_ack,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_w,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       mem_busy,
    output logic       mem_timeout
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic       r_valid_e, r_regwrt_e, r_load_e, r_memacc_e;
    logic [4:0] r_rs1_e, r_rs2_e, r_rd_e;
    logic       r_valid_m, r_regwrt_m, r_memacc_m;
    logic [4:0] r_rd_m;
    logic       r_valid_w, r_regwrt_w;
    logic [4:0] r_rd_w;

    logic w_load_d, w_tmo_hit, w_freeze, w_lu, w_br;

    assign w_load_d  = (rsltSrc_d == 2'b01);
    assign w_tmo_hit = (r_state == ST_WAIT) && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_freeze  = r_valid_m && r_memacc_m && !dmem_ack && !w_tmo_hit;
    assign w_lu      = valid_d && r_valid_e && r_load_e && (r_rd_e != 5'd0) &&
                       ((r_rd_e == rs1_d) || (r_rd_e == rs2_d));
    assign w_br      = pc_src_e && r_valid_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack || w_tmo_hit) r_state <= ST_RUN;
                    else                       r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // While frozen, E and M hold in place and W fills with bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_e  <= 1'b0;
            r_rs1_e    <= '0;
            r_rs2_e    <= '0;
            r_rd_e     <= '0;
            r_regwrt_e <= 1'b0;
            r_load_e   <= 1'b0;
            r_memacc_e <= 1'b0;
            r_valid_m  <= 1'b0;
            r_rd_m     <= '0;
            r_regwrt_m <= 1'b0;
            r_memacc_m <= 1'b0;
            r_valid_w  <= 1'b0;
            r_rd_w     <= '0;
            r_regwrt_w <= 1'b0;
        end else if (w_freeze) begin
            r_valid_w <= 1'b0;
        end else begin
            r_valid_w  <= r_valid_m;
            r_rd_w     <= r_rd_m;
            r_regwrt_w <= r_regwrt_m;
            r_valid_m  <= r_valid_e;
            r_rd_m     <= r_rd_e;
            r_regwrt_m <= r_regwrt_e;
            r_memacc_m <= r_memacc_e;
            r_valid_e  <= valid_d && !flush_e;
            r_rs1_e    <= rs1_d;
            r_rs2_e    <= rs2_d;
            r_rd_e     <= rd_d;
            r_regwrt_e <= regwrt_d;
            r_load_e   <= w_load_d;
            r_memacc_e <= memacc_d;
        end
    end

    // A taken branch kills the stalled instruction anyway, so it overrides load-use.
    always_comb begin
        stall_f = w_freeze || (w_lu && !w_br);
        stall_d = stall_f;
        stall_e = w_freeze;
        stall_m = w_freeze;
        flush_w = w_freeze;
        flush_d = !w_freeze && w_br;
        flush_e = !w_freeze && (w_br || w_lu);
    end

    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (r_valid_e) begin
            if (r_valid_m && r_regwrt_m && (r_rd_m != 5'd0) && (r_rd_m == r_rs1_e))
                fwd_a_e = 2'b10;
            else if (r_valid_w && r_regwrt_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs1_e))
                fwd_a_e = 2'b01;
            if (r_valid_m && r_regwrt_m && (r_rd_m != 5'd0) && (r_rd_m == r_rs2_e))
                fwd_b_e = 2'b10;
            else if (r_valid_w && r_regwrt_w && (r_rd_w != 5'd0) && (r_rd_w == r_rs2_e))
                fwd_b_e = 2'b01;
        end
    end

    assign mem_busy    = (r_state == ST_WAIT);
    assign mem_timeout = w_tmo_hit && !dmem_ack;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle queues its expected output vector,
// which is popped and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_d, regwrt_d, memacc_d, pc_src_e, dmem_ack;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic [1:0] rsltSrc_d;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       mem_busy, mem_timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];

    logic [12:0] obs;
    logic [12:0] Z, FRZ, FRZB, LU, BR;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrt_d(regwrt_d), .rsltSrc_d(rsltSrc_d), .memacc_d(memacc_d), .pc_src_e(pc_src_e),
        .dmem_ack(dmem_ack), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_busy(mem_busy), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                  fwd_a_e, fwd_b_e, mem_busy, mem_timeout};

    // vector: sf sd se sm fd fe fw fa[1:0] fb[1:0] busy tmo
    function automatic logic [12:0] ex(input logic sf, sd, se, sm, fd, fe, fw,
                                       input logic [1:0] fa, fb, input logic busy, tmo);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb, busy, tmo};
    endfunction

    task automatic chk_eq(input string tag, input logic [12:0] got, input logic [12:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (sf sd se sm fd fe fw fa fb busy tmo)",
                     tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) chk_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end

    task automatic drive(input string tag, input logic r, v, input logic [4:0] s1, s2, d,
                         input logic rw, ld, ma, br, ack, input logic [12:0] want);
        rst       = r;
        valid_d   = v;
        rs1_d     = s1;
        rs2_d     = s2;
        rd_d      = d;
        regwrt_d  = rw;
        rsltSrc_d = ld ? 2'b01 : 2'b00;
        memacc_d  = ma;
        pc_src_e  = br;
        dmem_ack  = ack;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag, input logic br, ack, input logic [12:0] want);
        drive(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, br, ack, want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Z    = '0;
        FRZ  = ex(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        FRZB = ex(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0);
        LU   = ex(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        BR   = ex(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0);
        rst = 1'b1; valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; regwrt_d = 0;
        rsltSrc_d = 0; memacc_d = 0; pc_src_e = 0; dmem_ack = 0;
        @(posedge clk); #1;

        drive("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        drive("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, Z);
        nop("idle", 0, 0, Z);

        // back-to-back forward from M
        drive("a_add5", 0, 1, 1, 2, 5, 1, 0, 0, 0, 0, Z);
        drive("a_sub",  0, 1, 5, 1, 6, 1, 0, 0, 0, 0, Z);
        nop("a_fwdM", 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        nop("a_nop", 0, 0, Z);

        // one instruction between: forward from W
        drive("b_add9", 0, 1, 1, 2, 9, 1, 0, 0, 0, 0, Z);
        drive("b_or10", 0, 1, 3, 4, 10, 1, 0, 0, 0, 0, Z);
        drive("b_sub",  0, 1, 9, 3, 11, 1, 0, 0, 0, 0, Z);
        nop("b_fwdW", 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));

        // rd = x0 never forwards
        drive("c_add0", 0, 1, 1, 2, 0, 1, 0, 0, 0, 0, Z);
        drive("c_sub",  0, 1, 0, 1, 6, 1, 0, 0, 0, 0, Z);
        nop("c_fwd0", 0, 0, Z);

        // M beats W when both match
        drive("p_add5a", 0, 1, 1, 2, 5, 1, 0, 0, 0, 0, Z);
        drive("p_add5b", 0, 1, 3, 4, 5, 1, 0, 0, 0, 0, Z);
        drive("p_sub",   0, 1, 5, 5, 7, 1, 0, 0, 0, 0, Z);
        nop("p_fwdMW", 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0));
        nop("p_nop", 0, 0, Z);

        // load-use: one bubble, then W forward
        drive("d_lw",   0, 1, 1, 0, 7, 1, 1, 1, 0, 0, Z);
        drive("d_lu",   0, 1, 7, 7, 8, 1, 0, 0, 0, 0, LU);
        drive("d_hold", 0, 1, 7, 7, 8, 1, 0, 0, 0, 1, Z);
        nop("d_fwdW", 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0));
        nop("d_nop", 0, 0, Z);

        // load to x0 creates no hazard
        drive("x_lw0",  0, 1, 1, 0, 0, 1, 1, 1, 0, 0, Z);
        drive("x_use0", 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, Z);
        nop("x_nop", 0, 1, Z);
        nop("x_nop2", 0, 0, Z);

        // taken branch overrides load-use
        drive("e_lw",    0, 1, 1, 0, 7, 1, 1, 1, 0, 0, Z);
        drive("e_br",    0, 1, 7, 1, 8, 1, 0, 0, 1, 0, BR);
        nop("e_after", 0, 1, Z);
        nop("e_nop", 0, 0, Z);

        // store waits 3 cycles then acks
        drive("f_sw",    0, 1, 1, 2, 0, 0, 0, 1, 0, 0, Z);
        drive("f_add14", 0, 1, 3, 4, 14, 1, 0, 0, 0, 0, Z);
        drive("f_frz1",  0, 1, 14, 0, 15, 1, 0, 0, 0, 0, FRZ);
        drive("f_frz2",  0, 1, 14, 0, 15, 1, 0, 0, 0, 0, FRZB);
        drive("f_frz3",  0, 1, 14, 0, 15, 1, 0, 0, 0, 0, FRZB);
        drive("f_ack",   0, 1, 14, 0, 15, 1, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
        nop("f_fwdM", 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        nop("f_nop", 0, 0, Z);

        // timeout: 4 frozen cycles, pulse, then advance
        drive("g_lw",   0, 1, 1, 0, 16, 1, 1, 1, 0, 0, Z);
        nop("g_nop", 0, 0, Z);
        drive("g_frz1", 0, 1, 16, 0, 17, 1, 0, 0, 0, 0, FRZ);
        drive("g_frz2", 0, 1, 16, 0, 17, 1, 0, 0, 0, 0, FRZB);
        drive("g_frz3", 0, 1, 16, 0, 17, 1, 0, 0, 0, 0, FRZB);
        drive("g_frz4", 0, 1, 16, 0, 17, 1, 0, 0, 0, 0, FRZB);
        drive("g_tmo",  0, 1, 16, 0, 17, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
        nop("g_fwdW", 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        nop("g_nop2", 0, 0, Z);

        // reset in the middle of WAIT
        drive("h_sw",  0, 1, 1, 2, 0, 0, 0, 1, 0, 0, Z);
        drive("h_add", 0, 1, 3, 4, 21, 1, 0, 0, 0, 0, Z);
        nop("h_frz", 1, 0, FRZ);
        nop("h_wait", 1, 0, FRZB);
        drive("h_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, Z);
        drive("h_idle0", 0, 0, 3, 4, 21, 1, 1, 1, 1, 0, Z);
        nop("h_idle1", 0, 0, Z);
        nop("h_idle2", 1, 0, Z);

        chk_eq("drain", 13'(exp_q.size()), 13'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
